// File: rtl/conv33_pkg.sv
// Shared constants for the conv33 window datapath.
// Window indices are row-major, top-left first.
package conv33_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int KERNEL     = 3;

    localparam int W_TL = 0;
    localparam int W_TM = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MM = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BM = 7;
    localparam int W_BR = 8;

    function automatic int win_bits(input int dw);
        return KERNEL * KERNEL * dw;
    endfunction

endpackage

// File: rtl/conv33_line_buffer.sv
// One image line of storage: registered write,
// combinational read at the same address.
module conv33_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 28,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents persist across frames; no reset needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/conv33_window_buffer.sv
// Raster pixel stream in, 3x3 sliding windows out.
// Two line buffers feed the right column of a shift array.
module conv33_window_buffer
    import conv33_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [win_bits(DATA_W)-1:0]   win_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = win_bits(DATA_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [WW-1:0]     shift_q, shift_d;
    logic [WW-1:0]     win_q, win_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] l0_rd, l1_rd;
    logic              accept, complete, at_end;

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out;
    assign complete  = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    assign at_end    = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign win_out   = win_q;
    assign valid_out = valid_q;
    assign done      = done_q;

    // line0 holds row r-1; line1 holds row r-2.
    conv33_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (CW)
    ) u_line0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (pix_in),
        .rdata (l0_rd)
    );

    conv33_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (CW)
    ) u_line1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (l0_rd),
        .rdata (l1_rd)
    );

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shift columns left; new right column is r-2, r-1, r.
    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                shift_d[(r*3+0)*DATA_W +: DATA_W] =
                    shift_q[(r*3+1)*DATA_W +: DATA_W];
                shift_d[(r*3+1)*DATA_W +: DATA_W] =
                    shift_q[(r*3+2)*DATA_W +: DATA_W];
            end
            shift_d[W_TR*DATA_W +: DATA_W] = l1_rd;
            shift_d[W_MR*DATA_W +: DATA_W] = l0_rd;
            shift_d[W_BR*DATA_W +: DATA_W] = pix_in;
        end
    end

    // Output register: load on a complete window, clear on drain.
    always_comb begin
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = valid_q && ready_in && last_q;
        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
        if (accept && complete) begin
            win_d   = shift_d;
            valid_d = 1'b1;
            last_d  = at_end;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            shift_q <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            shift_q <= shift_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_conv33_window_buffer.sv
// Bench for conv33_window_buffer: a 4x4 and a 28x28 instance
// checked against a frame-image window model.
module tb_conv33_window_buffer;

    typedef struct {
        logic [71:0] win;
        bit          last;
    } exp_t;

    localparam logic [71:0] W0 =
        {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] W100 =
        {8'd110, 8'd109, 8'd108, 8'd106, 8'd105,
         8'd104, 8'd102, 8'd101, 8'd100};

    logic        clk = 0;
    logic        rst = 1;

    logic [7:0]  a_pix = 0;
    logic        a_vin = 0;
    logic        a_rdy_out;
    logic [71:0] a_win;
    logic        a_vout;
    logic        a_rin = 1;
    logic        a_done;

    logic [7:0]  b_pix = 0;
    logic        b_vin = 0;
    logic        b_rdy_out;
    logic [71:0] b_win;
    logic        b_vout;
    logic        b_rin = 1;
    logic        b_done;

    int cmp = 0;
    int bad = 0;

    logic [7:0]  a_img [784];
    logic [7:0]  b_img [784];
    exp_t        a_q[$];
    exp_t        b_q[$];
    logic [71:0] a_log[$];
    int a_r = 0, a_c = 0, a_dn = 0;
    int b_r = 0, b_c = 0, b_dn = 0, b_cnt = 0;
    bit a_expd = 0, b_expd = 0;
    bit b_busy = 0;

    always #5 clk = ~clk;

    conv33_window_buffer #(
        .DATA_W (8), .IMG_W (4), .IMG_H (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (a_pix),
        .valid_in  (a_vin),
        .ready_out (a_rdy_out),
        .win_out   (a_win),
        .valid_out (a_vout),
        .ready_in  (a_rin),
        .done      (a_done)
    );

    conv33_window_buffer #(
        .DATA_W (8), .IMG_W (28), .IMG_H (28)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (b_pix),
        .valid_in  (b_vin),
        .ready_out (b_rdy_out),
        .win_out   (b_win),
        .valid_out (b_vout),
        .ready_in  (b_rin),
        .done      (b_done)
    );

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Window at (r,c) taken straight from the current frame image.
    function automatic logic [71:0] win_of(input logic [7:0] img [784],
                                           input int w, input int r,
                                           input int c);
        logic [71:0] res;
        res = '0;
        for (int k = 0; k < 9; k++)
            res[k*8 +: 8] = img[(r - 2 + k / 3) * w + (c - 2 + k % 3)];
        return res;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            a_r = 0; a_c = 0; a_expd = 0; a_q.delete();
        end else begin
            chk("a_done", 72'(a_done), 72'(a_expd));
            if (a_done) a_dn++;
            a_expd = 0;
            chk("a_ready", 72'(a_rdy_out), 72'(!a_vout || a_rin));
            if (a_vout && a_rin) begin
                if (a_q.size() == 0) begin
                    chk("a_extra_win", 72'(1), 72'(0));
                end else begin
                    exp_t e;
                    e = a_q.pop_front();
                    chk("a_win", a_win, e.win);
                    a_expd = e.last;
                    a_log.push_back(a_win);
                end
            end
            if (a_vin && a_rdy_out) begin
                a_img[a_r*4 + a_c] = a_pix;
                if (a_r >= 2 && a_c >= 2)
                    a_q.push_back('{win_of(a_img, 4, a_r, a_c),
                                    (a_r == 3 && a_c == 3)});
                a_c++;
                if (a_c == 4) begin a_c = 0; a_r = (a_r + 1) % 4; end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_r = 0; b_c = 0; b_expd = 0; b_q.delete();
        end else begin
            chk("b_done", 72'(b_done), 72'(b_expd));
            if (b_done) b_dn++;
            b_expd = 0;
            if (b_vout && b_rin) begin
                if (b_q.size() == 0) begin
                    chk("b_extra_win", 72'(1), 72'(0));
                end else begin
                    exp_t e;
                    e = b_q.pop_front();
                    chk("b_win", b_win, e.win);
                    b_expd = e.last;
                    b_cnt++;
                end
            end
            if (b_vin && b_rdy_out) begin
                b_img[b_r*28 + b_c] = b_pix;
                if (b_r >= 2 && b_c >= 2)
                    b_q.push_back('{win_of(b_img, 28, b_r, b_c),
                                    (b_r == 27 && b_c == 27)});
                b_c++;
                if (b_c == 28) begin b_c = 0; b_r = (b_r + 1) % 28; end
            end
        end
    end

    task automatic send_a(input logic [7:0] p);
        bit acc;
        int g;
        a_pix = p; a_vin = 1; acc = 0; g = 0;
        while (!acc && g < 200) begin
            @(negedge clk); acc = a_rdy_out;
            @(posedge clk); #1; g++;
        end
        if (!acc) chk("a_send_timeout", 72'(0), 72'(1));
        a_vin = 0;
    endtask

    task automatic send_b(input logic [7:0] p);
        bit acc;
        int g;
        b_pix = p; b_vin = 1; acc = 0; g = 0;
        while (!acc && g < 200) begin
            @(negedge clk); acc = b_rdy_out;
            @(posedge clk); #1; g++;
        end
        if (!acc) chk("b_send_timeout", 72'(0), 72'(1));
        b_vin = 0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        chk("rst_a_vout", 72'(a_vout), 72'(0));
        chk("rst_a_done", 72'(a_done), 72'(0));
        @(posedge clk); #1; rst = 0;
        a_log.delete(); a_dn = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_vout", 72'(a_vout), 72'(0));
        chk("reset_win", a_win, 72'(0));
        chk("reset_done", 72'(a_done), 72'(0));
        chk("reset_ready", 72'(a_rdy_out), 72'(1));
        chk("reset_b_vout", 72'(b_vout), 72'(0));
        @(posedge clk); #1; rst = 0;

        // Back-to-back 4x4 frame, downstream always ready.
        a_rin = 1;
        for (int p = 0; p < 16; p++) send_a(8'(p));
        repeat (6) @(posedge clk); #1;
        chk("t1_count", 72'(a_log.size()), 72'(4));
        chk("t1_first", (a_log.size() > 0) ? a_log[0] : '0, W0);
        chk("t1_done_cnt", 72'(a_dn), 72'(1));

        // Stall the first window for five cycles.
        pulse_rst();
        a_rin = 0;
        fork
            begin
                for (int p = 0; p < 16; p++) send_a(8'(p));
            end
            begin
                int g;
                g = 0;
                do begin @(negedge clk); g++; end
                while (!a_vout && g < 100);
                chk("t2_first_valid", 72'(a_vout), 72'(1));
                for (int i = 0; i < 5; i++) begin
                    chk("t2_hold_win", a_win, W0);
                    chk("t2_hold_ready", 72'(a_rdy_out), 72'(0));
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk); #1; a_rin = 1;
            end
        join
        repeat (6) @(posedge clk); #1;
        chk("t2_count", 72'(a_log.size()), 72'(4));
        chk("t2_first", (a_log.size() > 0) ? a_log[0] : '0, W0);
        chk("t2_done_cnt", 72'(a_dn), 72'(1));

        // Two frames back to back; frame 2 must not see frame 1.
        pulse_rst();
        for (int p = 0; p < 16; p++) send_a(8'(p));
        for (int p = 0; p < 16; p++) send_a(8'(100 + p));
        repeat (6) @(posedge clk); #1;
        chk("t4_count", 72'(a_log.size()), 72'(8));
        chk("t4_frame2_first", (a_log.size() > 4) ? a_log[4] : '0, W100);
        chk("t4_done_cnt", 72'(a_dn), 72'(2));

        // Reset after 9 pixels, then a clean frame.
        pulse_rst();
        for (int p = 0; p < 9; p++) send_a(8'(200 + p));
        rst = 1;
        @(negedge clk);
        chk("t5_rst_vout", 72'(a_vout), 72'(0));
        chk("t5_rst_done", 72'(a_done), 72'(0));
        chk("t5_rst_ready", 72'(a_rdy_out), 72'(1));
        @(posedge clk); #1; rst = 0;
        a_log.delete(); a_dn = 0;
        for (int p = 0; p < 16; p++) send_a(8'(p));
        repeat (6) @(posedge clk); #1;
        chk("t5_count", 72'(a_log.size()), 72'(4));
        chk("t5_first", (a_log.size() > 0) ? a_log[0] : '0, W0);
        chk("t5_done_cnt", 72'(a_dn), 72'(1));

        // 28x28 ramp with random input gaps and random ready_in.
        b_busy = 1;
        fork
            begin
                for (int p = 0; p < 784; p++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_b(8'(p % 256));
                end
                b_busy = 0;
            end
            begin
                int g;
                g = 0;
                while ((b_busy || b_cnt < 676) && g < 20000) begin
                    @(posedge clk); #1;
                    b_rin = ($urandom_range(0, 3) != 0);
                    g++;
                end
                b_rin = 1;
            end
        join
        repeat (6) @(posedge clk); #1;
        chk("t3_count", 72'(b_cnt), 72'(676));
        chk("t3_done_cnt", 72'(b_dn), 72'(1));
        chk("t3_queue_empty", 72'(b_q.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
